seq_op_engine: RTL and testbench

Parametrised multi-mode sequential arithmetic engine: the next generation of our dedicated control-unit/datapath microprocessor. A small FSM sequences a single add/subtract ALU over working registers X, Y and ACC. It computes series sum, repeated-add multiply or subtractive GCD on operands of configurable width, using a start/busy/done handshake. It sits as a slave compute block beside the host datapath.

---
 rtl/seq_op_engine_pkg.sv | 17 +
 rtl/seq_op_engine_if.sv | 28 ++
 rtl/seq_op_engine_ctrl.sv | 80 ++++++++
 rtl/seq_op_engine.sv | 146 ++++++++++++++
 tb/tb_seq_op_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_op_engine_pkg.sv
// Shared types for seq_op_engine: operating modes and controller states.
package seq_op_engine_pkg;

  typedef enum logic [1:0] {
    MODE_SUM = 2'd0,
    MODE_MUL = 2'd1,
    MODE_GCD = 2'd2,
    MODE_ILL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_op_engine_if.sv
// Start/busy/done handshake bundle between a host (master) and seq_op_engine (slave).
interface seq_op_engine_if
  import seq_op_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);

  logic                 start;
  mode_e                mode;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 busy;
  logic                 done;
  logic [ACC_WIDTH-1:0] result;
  logic                 error;

  modport master (
    output start, mode, a_in, b_in,
    input  busy, done, result, error
  );

  modport slave (
    input  start, mode, a_in, b_in,
    output busy, done, result, error
  );

endinterface

// File: rtl/seq_op_engine_ctrl.sv
// Controller FSM: decides termination from datapath flags and issues load/step/finish
// strobes plus ALU operand select and subtract enables.
module seq_op_engine_ctrl
  import seq_op_engine_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  mode_e mode,
  input  logic  x_zero,
  input  logic  y_zero,
  input  logic  x_eq_y,
  output logic  busy,
  output logic  done,
  output logic  load_en,
  output logic  step_en,
  output logic  finish_en,
  output logic  alu_sub,
  output logic  add_sel_x
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   term;

  assign alu_sub   = (mode == MODE_GCD);
  assign add_sel_x = (mode == MODE_MUL);
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    term = 1'b1;
    case (mode)
      MODE_SUM, MODE_MUL: term = y_zero;
      MODE_GCD:           term = x_zero | y_zero | x_eq_y;
      default:            term = 1'b1;
    endcase

    state_d   = state_q;
    load_en   = 1'b0;
    step_en   = 1'b0;
    finish_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          load_en = 1'b1;
        end
      end
      S_RUN: begin
        if (term) begin
          state_d   = S_DONE;
          finish_en = 1'b1;
        end else begin
          step_en = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/seq_op_engine.sv
// Multi-mode sequential arithmetic engine (SUM / MUL / GCD) with one shared add/sub ALU.
// Define SEQ_OP_ENGINE_SAT_EN to clamp accumulator overflow and report it through error.
module seq_op_engine
  import seq_op_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  seq_op_engine_if.slave bus
);

  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef logic [ACC_WIDTH:0]   alu_t;

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  acc_t             acc_q, acc_d;
  acc_t             result_q, result_d;
  logic             error_q, error_d;

  logic x_zero, y_zero, x_eq_y, x_gt_y;
  logic load_en, step_en, finish_en, alu_sub, add_sel_x;
  logic mode_err;
  alu_t alu_a, alu_b, alu_res;
  acc_t acc_next;

`ifdef SEQ_OP_ENGINE_SAT_EN
  logic ovf_q, ovf_d;
`else
  logic unused_carry;
`endif

  seq_op_engine_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .mode      (mode_q),
    .x_zero    (x_zero),
    .y_zero    (y_zero),
    .x_eq_y    (x_eq_y),
    .busy      (bus.busy),
    .done      (bus.done),
    .load_en   (load_en),
    .step_en   (step_en),
    .finish_en (finish_en),
    .alu_sub   (alu_sub),
    .add_sel_x (add_sel_x)
  );

  assign x_zero   = (x_q == '0);
  assign y_zero   = (y_q == '0);
  assign x_eq_y   = (x_q == y_q);
  assign x_gt_y   = (x_q > y_q);
  assign mode_err = (mode_q == MODE_ILL) || ((mode_q == MODE_GCD) && x_zero && y_zero);

  // GCD always subtracts the smaller register from the larger one.
  assign alu_a   = alu_sub ? (x_gt_y ? alu_t'(x_q) : alu_t'(y_q)) : alu_t'(acc_q);
  assign alu_b   = alu_sub ? (x_gt_y ? alu_t'(y_q) : alu_t'(x_q))
                           : (add_sel_x ? alu_t'(x_q) : alu_t'(y_q));
  assign alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

`ifdef SEQ_OP_ENGINE_SAT_EN
  assign acc_next = alu_res[ACC_WIDTH] ? '1 : alu_res[ACC_WIDTH-1:0];
`else
  assign acc_next     = alu_res[ACC_WIDTH-1:0];
  assign unused_carry = alu_res[ACC_WIDTH];
`endif

  always_comb begin
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    result_d = result_q;
    error_d  = error_q;
`ifdef SEQ_OP_ENGINE_SAT_EN
    ovf_d    = ovf_q;
`endif

    if (load_en) begin
      mode_d   = bus.mode;
      x_d      = (bus.mode == MODE_SUM) ? '0 : bus.a_in;
      y_d      = (bus.mode == MODE_SUM) ? bus.a_in : bus.b_in;
      acc_d    = '0;
      result_d = '0;
      error_d  = 1'b0;
`ifdef SEQ_OP_ENGINE_SAT_EN
      ovf_d    = 1'b0;
`endif
    end

    if (step_en) begin
      if (mode_q == MODE_GCD) begin
        if (x_gt_y) x_d = alu_res[WIDTH-1:0];
        else        y_d = alu_res[WIDTH-1:0];
      end else begin
        acc_d = acc_next;
        y_d   = y_q - WIDTH'(1);
`ifdef SEQ_OP_ENGINE_SAT_EN
        ovf_d = ovf_q | alu_res[ACC_WIDTH];
`endif
      end
    end

    // At termination of GCD, X|Y is X when equal and the non-zero operand otherwise.
    if (finish_en) begin
      result_d = (mode_q == MODE_GCD) ? acc_t'(x_q | y_q) : acc_q;
`ifdef SEQ_OP_ENGINE_SAT_EN
      error_d  = mode_err | ovf_q;
`else
      error_d  = mode_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_SUM;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
`ifdef SEQ_OP_ENGINE_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      mode_q   <= mode_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      error_q  <= error_d;
`ifdef SEQ_OP_ENGINE_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_seq_op_engine.sv
// Self-checking bench for seq_op_engine: directed and random operations against an
// arithmetic reference model, plus a narrow-accumulator instance for overflow behaviour.
module tb_seq_op_engine;
  import seq_op_engine_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;

  always #5 clk = ~clk;

  seq_op_engine_if #(.WIDTH(8), .ACC_WIDTH(16)) bus ();
  seq_op_engine_if #(.WIDTH(8), .ACC_WIDTH(8))  bus8 ();

  seq_op_engine #(.WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_op_engine #(.WIDTH(8), .ACC_WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Closed-form results; GCD step count via division-based Euclid.
  function automatic void refModel(input int m, input int a, input int b, input int acc_w,
                                   output int res, output int err, output int k);
    longint v;
    longint lim;
    int     x;
    int     y;
    int     steps;
    lim = (longint'(1) << acc_w) - 1;
    res = 0;
    err = 0;
    k   = 1;
    case (m)
      0, 1: begin
        v = (m == 0) ? (longint'(a) * (a + 1)) / 2 : longint'(a) * b;
        k = ((m == 0) ? a : b) + 1;
`ifdef SEQ_OP_ENGINE_SAT_EN
        if (v > lim) begin
          v   = lim;
          err = 1;
        end
`endif
        res = int'(v & lim);
      end
      2: begin
        x = a;
        y = b;
        steps = 0;
        while (x != 0 && y != 0 && x != y) begin
          if (x > y) begin
            if (x % y == 0) begin steps += x / y - 1; x = y; end
            else begin steps += x / y; x = x % y; end
          end else begin
            if (y % x == 0) begin steps += y / x - 1; y = x; end
            else begin steps += y / x; y = y % x; end
          end
        end
        res = x | y;
        err = (a == 0 && b == 0) ? 1 : 0;
        k   = steps + 1;
      end
      default: begin
        res = 0;
        err = 1;
        k   = 1;
      end
    endcase
  endfunction

  task automatic applyStimulus(input string name, input int m, input int a, input int b, input bit hold_start);
    int exp_res, exp_err, k;
    int busy_cnt, done_cnt, done_cyc;
    logic [31:0] res_at_done, err_at_done;
    bit finished;
    refModel(m, a, b, 16, exp_res, exp_err, k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = mode_e'(m[1:0]);
    bus.a_in  = a[7:0];
    bus.b_in  = b[7:0];
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; finished = 1'b0;
    res_at_done = '1; err_at_done = '1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (!hold_start) bus.start = 1'b0;
      bus.a_in = 8'($urandom);
      bus.b_in = 8'($urandom);
      bus.mode = mode_e'($urandom_range(0, 3));
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc    = c;
        res_at_done = 32'(bus.result);
        err_at_done = 32'(bus.error);
      end
      if (!bus.busy) begin
        finished  = 1'b1;
        bus.start = 1'b0;
        break;
      end
    end
    checkOutput({name, " complete"}, 32'(finished), 32'd1);
    checkOutput({name, " done_cycle"}, done_cyc, k + 1);
    checkOutput({name, " busy_cycles"}, busy_cnt, k + 1);
    checkOutput({name, " done_pulses"}, done_cnt, 1);
    checkOutput({name, " result"}, res_at_done, exp_res);
    checkOutput({name, " error"}, err_at_done, exp_err);
    checkOutput({name, " result_held"}, 32'(bus.result), exp_res);
  endtask

  task automatic runNarrow(input string name, input int m, input int a, input int b);
    int exp_res, exp_err, k;
    bit seen;
    logic [31:0] r, e;
    refModel(m, a, b, 8, exp_res, exp_err, k);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.mode  = mode_e'(m[1:0]);
    bus8.a_in  = a[7:0];
    bus8.b_in  = b[7:0];
    seen = 1'b0; r = '1; e = '1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done) begin
        seen = 1'b1;
        r = 32'(bus8.result);
        e = 32'(bus8.error);
        break;
      end
    end
    checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
    checkOutput({name, " result"}, r, exp_res);
    checkOutput({name, " error"}, e, exp_err);
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = MODE_SUM;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus8.start = 1'b0;
    bus8.mode  = MODE_SUM;
    bus8.a_in  = '0;
    bus8.b_in  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    checkOutput("reset error", 32'(bus.error), 32'd0);
    reset = 1'b0;

    applyStimulus("sum10", 0, 10, 0, 1'b0);
    applyStimulus("mul13x0", 1, 13, 0, 1'b0);
    applyStimulus("mul255x255", 1, 255, 255, 1'b0);
    applyStimulus("gcd48_18", 2, 48, 18, 1'b0);
    applyStimulus("gcd0_9", 2, 0, 9, 1'b0);
    applyStimulus("gcd0_0", 2, 0, 0, 1'b0);
    applyStimulus("illegal", 3, 5, 7, 1'b0);
    applyStimulus("sum5_hold", 0, 5, 0, 1'b1);
    applyStimulus("sum0", 0, 0, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("rnd%0d", i), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
    end

    // Reset in the middle of a long SUM run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = MODE_SUM;
    bus.a_in  = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrun busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset done", 32'(bus.done), 32'd0);
    checkOutput("midreset result", 32'(bus.result), 32'd0);
    checkOutput("midreset error", 32'(bus.error), 32'd0);
    reset = 1'b0;
    applyStimulus("after_reset_sum3", 0, 3, 0, 1'b0);

    runNarrow("narrow_mul20x20", 1, 20, 20);
    runNarrow("narrow_sum30", 0, 30, 0);
    runNarrow("narrow_gcd35_21", 2, 35, 21);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
